// File: rtl/tx_iq_intf_mc.sv
// TX IQ interface: per-channel digital gain, FWFT sample FIFO with hold
// back-pressure, and a source mux selecting between the core path and s_axis.
// Build option: define TX_IQ_SATURATE_EN to saturate the scaled samples
// instead of wrapping them.
module tx_iq_intf_mc #(
    parameter int C_S00_AXIS_TDATA_WIDTH = 64,
    parameter int IQ_DATA_WIDTH          = 16,
    parameter int NUM_CH                 = 2,
    parameter int FIFO_AW                = 9
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic [IQ_DATA_WIDTH*NUM_CH-1:0]       rf_i,
    input  logic [IQ_DATA_WIDTH*NUM_CH-1:0]       rf_q,
    input  logic                                  rf_iq_valid,
    input  logic [10*NUM_CH-1:0]                  bb_gain,
    input  logic [FIFO_AW:0]                      tx_hold_threshold,
    input  logic                                  src_sel,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     data_from_s_axis,
    input  logic                                  emptyn_from_s_axis,
    output logic                                  ask_data_from_s_axis,
    output logic [2*IQ_DATA_WIDTH*NUM_CH-1:0]     wifi_iq_pack,
    output logic                                  wifi_iq_valid,
    input  logic                                  wifi_iq_ready,
    output logic                                  tx_hold,
    output logic                                  tx_iq_fifo_empty,
    output logic                                  tx_iq_fifo_rden,
    output logic [FIFO_AW:0]                      data_count,
    output logic [15:0]                           underrun_count
);

    localparam int IQW = IQ_DATA_WIDTH;
    localparam int PW  = IQW + 10;               // full-precision product width
    localparam int DW  = 2 * IQW * NUM_CH;
    localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    logic signed [PW-1:0] prod_i_d [NUM_CH];
    logic signed [PW-1:0] prod_q_d [NUM_CH];
    logic signed [PW-1:0] prod_i_q [NUM_CH];
    logic signed [PW-1:0] prod_q_q [NUM_CH];
    logic                 wren_d, wren_q;

    logic [DW-1:0]        fifo_wdata;
    logic [DW-1:0]        fifo_head;
    logic [DW-1:0]        mem [2**FIFO_AW];
    logic [FIFO_AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]     count_q;
    logic                 full, empty, do_wr, do_rd;

    logic                 src_sel_q, flush_q;
    state_e               state_q;
    logic [15:0]          underrun_q;

    // Sign-extend both operands to the product width so the multiply is exact.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            prod_i_d[c] = $signed({{10{rf_i[c*IQW+IQW-1]}}, rf_i[c*IQW +: IQW]}) *
                          $signed({{IQW{bb_gain[c*10+9]}}, bb_gain[c*10 +: 10]});
            prod_q_d[c] = $signed({{10{rf_q[c*IQW+IQW-1]}}, rf_q[c*IQW +: IQW]}) *
                          $signed({{IQW{bb_gain[c*10+9]}}, bb_gain[c*10 +: 10]});
        end
    end

    assign wren_d = ~src_sel & rf_iq_valid & ~tx_hold & ~full;

    // Gain stage and its write strobe advance together.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int c = 0; c < NUM_CH; c++) begin
                prod_i_q[c] <= '0;
                prod_q_q[c] <= '0;
            end
            wren_q <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                prod_i_q[c] <= prod_i_d[c];
                prod_q_q[c] <= prod_q_d[c];
            end
            wren_q <= wren_d;
        end
    end

    // Scale by >>7 and pack each channel as {Q, I}, channel 0 in the LSBs.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_scale
        logic [IQW-1:0] scaled_i, scaled_q;
        logic           unused_prod_bits;
`ifdef TX_IQ_SATURATE_EN
        logic [3:0]     hi_i, hi_q;
        assign hi_i = prod_i_q[c][PW-1:IQW+6];
        assign hi_q = prod_q_q[c][PW-1:IQW+6];
        assign scaled_i = (hi_i == 4'h0 || hi_i == 4'hF) ? prod_i_q[c][IQW+6:7] :
                          hi_i[3] ? {1'b1, {(IQW-1){1'b0}}} : {1'b0, {(IQW-1){1'b1}}};
        assign scaled_q = (hi_q == 4'h0 || hi_q == 4'hF) ? prod_q_q[c][IQW+6:7] :
                          hi_q[3] ? {1'b1, {(IQW-1){1'b0}}} : {1'b0, {(IQW-1){1'b1}}};
`else
        assign scaled_i = prod_i_q[c][IQW+6:7];
        assign scaled_q = prod_q_q[c][IQW+6:7];
`endif
        assign unused_prod_bits = ^{prod_i_q[c][PW-1:IQW+7], prod_i_q[c][6:0],
                                    prod_q_q[c][PW-1:IQW+7], prod_q_q[c][6:0]};
        assign fifo_wdata[c*2*IQW +: 2*IQW] = {scaled_q, scaled_i};
    end

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign do_wr     = wren_q & ~full & ~src_sel;
    assign do_rd     = ~src_sel & wifi_iq_ready & ~empty;
    assign fifo_head = mem[rd_ptr_q];

    // Sample storage; no reset, content is qualified by the pointers.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q] <= fifo_wdata;
        end
    end

    // FIFO pointers and exact occupancy; flush has priority over traffic.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_q) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
            count_q <= count_q + (FIFO_AW+1)'(do_wr) - (FIFO_AW+1)'(do_rd);
        end
    end

    // Registered src_sel edge detect drives the synchronous flush.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            src_sel_q <= 1'b0;
            flush_q   <= 1'b0;
        end else begin
            src_sel_q <= src_sel;
            flush_q   <= src_sel ^ src_sel_q;
        end
    end

    // Stream FSM: counts underruns once a stream has started on the core path.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            underrun_q <= '0;
        end else if (flush_q) begin
            state_q    <= StIdle;
            underrun_q <= '0;
        end else if (src_sel) begin
            state_q    <= StIdle;
        end else begin
            unique case (state_q)
                StIdle: if (do_rd) state_q <= StRun;
                StRun: begin
                    if (wifi_iq_ready && empty) begin
                        state_q <= StIdle;
                        if (underrun_q != 16'hFFFF) underrun_q <= underrun_q + 16'd1;
                    end
                end
            endcase
        end
    end

    // Output mux between FIFO head and s_axis passthrough.
    always_comb begin
        tx_hold              = (count_q > tx_hold_threshold);
        tx_iq_fifo_empty     = empty;
        tx_iq_fifo_rden      = do_rd;
        data_count           = count_q;
        underrun_count       = underrun_q;
        if (src_sel) begin
            wifi_iq_pack         = data_from_s_axis[DW-1:0];
            wifi_iq_valid        = emptyn_from_s_axis;
            ask_data_from_s_axis = wifi_iq_ready;
        end else begin
            wifi_iq_pack         = fifo_head;
            wifi_iq_valid        = ~empty;
            ask_data_from_s_axis = 1'b0;
        end
    end

endmodule
